// File: rtl/alsu_pkg.sv
// Shared opcodes and width helper for the pipelined ALSU.
// Imported by the datapath top and the bench.
package alsu_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_XOR  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b011;
  localparam logic [2:0] OP_SHF  = 3'b100;
  localparam logic [2:0] OP_ROT  = 3'b101;
  localparam logic [2:0] OP_INV6 = 3'b110;
  localparam logic [2:0] OP_INV7 = 3'b111;

  function automatic int OUT_W(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/alsu_err_blink.sv
// LED blink window started by an error delivery.
// Divider counter paces toggles; toggle counter ends the window.
module alsu_err_blink #(
  parameter int BLINK_DIV  = 25000000,
  parameter int BLINK_HOLD = 4
) (
  input  logic        clock_100Mhz,
  input  logic        rst,
  input  logic        trigger,
  output logic [15:0] leds
);

  localparam int DW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int TW = $clog2(BLINK_HOLD + 1);
  localparam logic [DW-1:0] DIV_END = DW'(BLINK_DIV - 1);
  localparam logic [TW-1:0] TOG_END = TW'(BLINK_HOLD - 1);

  logic [DW-1:0] div;
  logic [TW-1:0] tog;
  logic          active;
  logic          phase;

  // Restart in ON phase on trigger, else count toggles until the window ends
  always_ff @(posedge clock_100Mhz or posedge rst) begin
    if (rst) begin
      div    <= '0;
      tog    <= '0;
      active <= 1'b0;
      phase  <= 1'b0;
    end else if (trigger) begin
      div    <= '0;
      tog    <= '0;
      active <= 1'b1;
      phase  <= 1'b1;
    end else if (active) begin
      if (div == DIV_END) begin
        div   <= '0;
        tog   <= tog + 1'b1;
        phase <= ~phase;
        if (tog == TOG_END) begin
          active <= 1'b0;
          phase  <= 1'b0;
        end
      end else begin
        div <= div + 1'b1;
      end
    end
  end

  assign leds = {16{phase}};

endmodule

// File: rtl/alsu_pipe.sv
// Two-stage ALSU with valid/ready on both sides, error flag,
// saturating error counter and LED blink window on error.
module alsu_pipe
  import alsu_pkg::*;
#(
  parameter int    WIDTH      = 3,
  parameter string INPUT_PRIO = "A",
  parameter int    FULL_ADDER = 1,
  parameter int    ERR_CNT_W  = 8,
  parameter int    BLINK_DIV  = 25000000,
  parameter int    BLINK_HOLD = 4
) (
  input  logic                       clock_100Mhz,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           A,
  input  logic [WIDTH-1:0]           B,
  input  logic [2:0]                 op_code,
  input  logic                       c_in,
  input  logic                       s_in,
  input  logic                       direction,
  input  logic                       red_op_A,
  input  logic                       red_op_B,
  input  logic                       bypass_A,
  input  logic                       bypass_B,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W(WIDTH)-1:0]    out,
  output logic                       err,
  output logic [ERR_CNT_W-1:0]       err_count,
  output logic [15:0]                leds
);

  localparam int OW  = OUT_W(WIDTH);
  localparam int PAD = OW - WIDTH;
  localparam bit PRIO_A = (INPUT_PRIO == "A");
  localparam bit USE_CIN = (FULL_ADDER != 0);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             c_in;
    logic             s_in;
    logic             dir;
    logic             red_a;
    logic             red_b;
    logic             byp_a;
    logic             byp_b;
  } bundle_t;

  function automatic logic [OW:0] compute(
    input bundle_t        bd,
    input logic [OW-1:0]  acc_q
  );
    logic [OW-1:0] ea;
    logic [OW-1:0] eb;
    logic [OW-1:0] ec;
    logic [OW-1:0] res;
    logic          e;
    logic          sel_a;
    ea    = {{PAD{1'b0}}, bd.a};
    eb    = {{PAD{1'b0}}, bd.b};
    ec    = {{(OW-1){1'b0}}, bd.c_in & USE_CIN};
    res   = '0;
    e     = 1'b0;
    sel_a = bd.red_a && (!bd.red_b || PRIO_A);
    if (bd.byp_a && bd.byp_b) begin
      res = PRIO_A ? ea : eb;
    end else if (bd.byp_a) begin
      res = ea;
    end else if (bd.byp_b) begin
      res = eb;
    end else begin
      unique case (bd.op)
        OP_AND: begin
          if (bd.red_a || bd.red_b)
            res = {{(OW-1){1'b0}}, sel_a ? &bd.a : &bd.b};
          else
            res = ea & eb;
        end
        OP_XOR: begin
          if (bd.red_a || bd.red_b)
            res = {{(OW-1){1'b0}}, sel_a ? ^bd.a : ^bd.b};
          else
            res = ea ^ eb;
        end
        OP_ADD: res = ea + eb + ec;
        OP_MUL: res = ea * eb;
        OP_SHF: res = bd.dir ? {acc_q[OW-2:0], bd.s_in}
                             : {bd.s_in, acc_q[OW-1:1]};
        OP_ROT: res = bd.dir ? {acc_q[OW-2:0], acc_q[OW-1]}
                             : {acc_q[0], acc_q[OW-1:1]};
        default: e = 1'b1;
      endcase
      if ((bd.op == OP_ADD || bd.op == OP_MUL ||
           bd.op == OP_SHF || bd.op == OP_ROT) &&
          (bd.red_a || bd.red_b))
        e = 1'b1;
      if (e) res = '0;
    end
    return {e, res};
  endfunction

  bundle_t       s1_q;
  bundle_t       in_b;
  logic          s1_v;
  logic          rdy_en;
  logic          acc_in;
  logic          s2_load;
  logic          deliver;
  logic [OW-1:0] acc;
  logic [OW:0]   c_res;

  assign in_b = '{a: A, b: B, op: op_code, c_in: c_in, s_in: s_in,
                  dir: direction, red_a: red_op_A, red_b: red_op_B,
                  byp_a: bypass_A, byp_b: bypass_B};

  assign in_ready = rdy_en && (!s1_v || !out_valid || out_ready);
  assign acc_in   = in_valid && in_ready;
  assign s2_load  = s1_v && (!out_valid || out_ready);
  assign deliver  = out_valid && out_ready;
  assign c_res    = compute(s1_q, acc);

  // Hold off acceptance until the first clock after reset
  always_ff @(posedge clock_100Mhz or posedge rst) begin
    if (rst) rdy_en <= 1'b0;
    else     rdy_en <= 1'b1;
  end

  // Stage 1: register the accepted bundle
  always_ff @(posedge clock_100Mhz or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s1_v <= 1'b0;
    end else if (acc_in) begin
      s1_q <= in_b;
      s1_v <= 1'b1;
    end else if (s2_load) begin
      s1_v <= 1'b0;
    end
  end

  // Stage 2: compute, hold under backpressure, track accumulator
  always_ff @(posedge clock_100Mhz or posedge rst) begin
    if (rst) begin
      out       <= '0;
      err       <= 1'b0;
      out_valid <= 1'b0;
      acc       <= '0;
    end else if (s2_load) begin
      out       <= c_res[OW-1:0];
      err       <= c_res[OW];
      out_valid <= 1'b1;
      if (!c_res[OW]) acc <= c_res[OW-1:0];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Saturating count of delivered error results
  always_ff @(posedge clock_100Mhz or posedge rst) begin
    if (rst)
      err_count <= '0;
    else if (deliver && err && err_count != '1)
      err_count <= err_count + 1'b1;
  end

  alsu_err_blink #(
    .BLINK_DIV  (BLINK_DIV),
    .BLINK_HOLD (BLINK_HOLD)
  ) u_blink (
    .clock_100Mhz (clock_100Mhz),
    .rst          (rst),
    .trigger      (deliver && err),
    .leds         (leds)
  );

endmodule

// File: tb/tb_alsu_pipe.sv
// Directed bench for alsu_pipe (WIDTH=3, BLINK_DIV=4).
// Expected values are hand-computed constants.
module tb_alsu_pipe;
  import alsu_pkg::*;

  logic        clock_100Mhz = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  A;
  logic [2:0]  B;
  logic [2:0]  op_code;
  logic        c_in;
  logic        s_in;
  logic        direction;
  logic        red_op_A;
  logic        red_op_B;
  logic        bypass_A;
  logic        bypass_B;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out;
  logic        err;
  logic [7:0]  err_count;
  logic [15:0] leds;

  int total = 0;
  int bad   = 0;

  always #5 clock_100Mhz = ~clock_100Mhz;

  alsu_pipe #(
    .WIDTH      (3),
    .INPUT_PRIO ("A"),
    .FULL_ADDER (1),
    .ERR_CNT_W  (8),
    .BLINK_DIV  (4),
    .BLINK_HOLD (4)
  ) dut (
    .clock_100Mhz (clock_100Mhz),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .A            (A),
    .B            (B),
    .op_code      (op_code),
    .c_in         (c_in),
    .s_in         (s_in),
    .direction    (direction),
    .red_op_A     (red_op_A),
    .red_op_B     (red_op_B),
    .bypass_A     (bypass_A),
    .bypass_B     (bypass_B),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out          (out),
    .err          (err),
    .err_count    (err_count),
    .leds         (leds)
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic do_op(
    input  logic [2:0] a_i, b_i, op_i,
    input  logic       cin_i, sin_i, dir_i,
    input  logic       ra_i, rb_i, ba_i, bb_i,
    output logic [5:0] o,
    output logic       e,
    output int         lat
  );
    int n;
    @(negedge clock_100Mhz);
    A = a_i; B = b_i; op_code = op_i;
    c_in = cin_i; s_in = sin_i; direction = dir_i;
    red_op_A = ra_i; red_op_B = rb_i;
    bypass_A = ba_i; bypass_B = bb_i;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 10) begin
      @(negedge clock_100Mhz);
      n++;
    end
    chk("accept", int'(in_ready), 1);
    @(negedge clock_100Mhz);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clock_100Mhz);
      lat++;
    end
    chk("out_valid", int'(out_valid), 1);
    o = out;
    e = err;
  endtask

  logic [5:0] o;
  logic       e;
  int         lat;
  logic [5:0] exp_q [5];
  int         sent;
  int         got;
  bit         stale;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; op_code = '0;
    c_in = 0; s_in = 0; direction = 0;
    red_op_A = 0; red_op_B = 0; bypass_A = 0; bypass_B = 0;
    exp_q = '{6'd1, 6'd3, 6'd5, 6'd7, 6'd9};

    repeat (3) @(negedge clock_100Mhz);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out", int'(out), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_err_count", int'(err_count), 0);
    chk("rst_leds", int'(leds), 0);
    rst = 1'b0;
    @(negedge clock_100Mhz);
    chk("in_ready_after_rst", int'(in_ready), 1);

    // add with carry and latency
    do_op(5, 3, OP_ADD, 1, 0, 0, 0, 0, 0, 0, o, e, lat);
    chk("add_out", int'(o), 9);
    chk("add_err", int'(e), 0);
    chk("add_latency", lat, 2);

    // mul then shift/rotate on accumulator
    do_op(7, 6, OP_MUL, 0, 0, 0, 0, 0, 0, 0, o, e, lat);
    chk("mul_out", int'(o), 42);
    do_op(0, 0, OP_SHF, 0, 1, 1, 0, 0, 0, 0, o, e, lat);
    chk("shl_out", int'(o), 21);
    do_op(0, 0, OP_ROT, 0, 0, 0, 0, 0, 0, 0, o, e, lat);
    chk("rotr_out", int'(o), 42);

    // error result and blink window
    do_op(1, 1, OP_ADD, 0, 0, 0, 1, 0, 0, 0, o, e, lat);
    chk("err_add_out", int'(o), 0);
    chk("err_add_err", int'(e), 1);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock_100Mhz);
      if (i == 1) chk("err_count_1", int'(err_count), 1);
      if (i == 2 || i == 10) chk("leds_on", int'(leds), 16'hffff);
      if (i == 6 || i == 14 || i == 20) chk("leds_off", int'(leds), 0);
    end
    do_op(0, 0, OP_ROT, 0, 0, 1, 0, 0, 0, 0, o, e, lat);
    chk("acc_kept_rotl", int'(o), 21);

    // bypass, reductions, bitwise, invalid
    do_op(2, 5, OP_ADD, 0, 0, 0, 0, 0, 1, 1, o, e, lat);
    chk("bypass_both", int'(o), 2);
    do_op(2, 5, OP_ADD, 0, 0, 0, 0, 0, 0, 1, o, e, lat);
    chk("bypass_b", int'(o), 5);
    do_op(7, 3, OP_AND, 0, 0, 0, 1, 1, 0, 0, o, e, lat);
    chk("and_red_both", int'(o), 1);
    do_op(0, 7, OP_XOR, 0, 0, 0, 0, 1, 0, 0, o, e, lat);
    chk("xor_red_b", int'(o), 1);
    do_op(5, 3, OP_XOR, 0, 0, 0, 0, 0, 0, 0, o, e, lat);
    chk("xor_bitwise", int'(o), 6);
    do_op(7, 7, OP_MUL, 0, 0, 0, 0, 0, 0, 0, o, e, lat);
    chk("mul_max", int'(o), 49);
    do_op(3, 3, OP_INV6, 0, 0, 0, 0, 0, 0, 0, o, e, lat);
    chk("inv_out", int'(o), 0);
    chk("inv_err", int'(e), 1);
    @(negedge clock_100Mhz);
    chk("err_count_2", int'(err_count), 2);

    // stream under backpressure
    sent = 0;
    got  = 0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      @(negedge clock_100Mhz);
      out_ready = (c >= 4);
      in_valid  = (sent < 5);
      A = 3'(sent); B = 3'(sent + 1); op_code = OP_ADD;
      c_in = 0; red_op_A = 0; red_op_B = 0;
      bypass_A = 0; bypass_B = 0;
      #1;
      if (c == 2 || c == 3) begin
        chk("bp_in_ready", int'(in_ready), 0);
        chk("bp_hold_out", int'(out), 1);
        chk("bp_accepts", sent, 2);
      end
      if (out_valid && out_ready) begin
        chk("stream_out", int'(out), int'(exp_q[got]));
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0;
    chk("stream_count", got, 5);

    // reset with two bundles in flight
    @(negedge clock_100Mhz);
    out_ready = 1'b0;
    in_valid = 1'b1; A = 1; B = 1; op_code = OP_ADD;
    @(negedge clock_100Mhz);
    A = 2;
    @(negedge clock_100Mhz);
    in_valid = 1'b0;
    chk("inflight_valid", int'(out_valid), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_out", int'(out), 0);
    chk("mid_rst_err_count", int'(err_count), 0);
    @(negedge clock_100Mhz);
    rst = 1'b0;
    out_ready = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock_100Mhz);
      if (out_valid) stale = 1'b1;
    end
    chk("no_stale_result", int'(stale), 0);
    chk("ready_after_mid_rst", int'(in_ready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
